// File: rtl/smart_home_pkg.sv
// Shared definitions for the home sensor/alarm reporting path:
// alarm ids, the event-transmitter FSM states and UART line levels.
package smart_home_pkg;

    typedef enum logic [2:0] {
        ALM_FIRE  = 3'd0,
        ALM_DOOR  = 3'd1,
        ALM_WIN0  = 3'd2,
        ALM_WIN1  = 3'd3,
        ALM_WIN2  = 3'd4,
        ALM_WIN3  = 3'd5,
        ALM_RAIN  = 3'd6,
        ALM_WATER = 3'd7
    } alarm_id_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_ACK
    } state_t;

    localparam int EVT_ASSERT = 7;

    localparam logic UART_IDLE      = 1'b1;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    // Event byte layout: {assert, 4'b0000, id}.
    function automatic logic [7:0] make_event(input logic is_assert, input logic [2:0] id);
        logic [7:0] b;
        b = {5'b00000, id};
        b[EVT_ASSERT] = is_assert;
        return b;
    endfunction

endpackage

// File: rtl/alarm_event_tx_if.sv
// Bundle between the alarm sources/panel (master) and the event transmitter (slave).
interface alarm_event_tx_if;
    import smart_home_pkg::*;

    // ack is a level or pulse from the panel; it is only honoured while the
    // transmitter waits for it after a stop bit, and is never stored otherwise.
    logic [7:0] alarm_in;
    logic       ack;
    logic       tx;
    logic       busy;
    logic       tx_fail;
    logic [2:0] fail_id;
    state_t     state;

    modport master (output alarm_in, ack, input tx, busy, tx_fail, fail_id, state);
    modport slave  (input alarm_in, ack, output tx, busy, tx_fail, fail_id, state);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 serialiser: start pulse latches data_in, done is high during the last
// cycle of the stop bit. bit_idx: 0 start, 1..8 data, 9 stop.
module uart_tx_byte
    import smart_home_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       bit_tick,
    output logic [3:0] bit_idx,
    output logic       done
);

    localparam int BW = $clog2(BAUD_DIV);

    logic [BW-1:0] baud_cnt;
    logic [7:0]    shreg;
    logic          active;

    assign bit_tick = active && (baud_cnt == BW'(BAUD_DIV - 1));
    assign done     = bit_tick && (bit_idx == 4'd9);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx       <= UART_IDLE;
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (start) begin
            tx       <= UART_START_BIT;
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= data_in;
        end else if (active) begin
            if (bit_tick) begin
                baud_cnt <= '0;
                // After the stop bit the line simply stays at the stop level.
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd8) begin
                        tx <= UART_STOP_BIT;
                    end else begin
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alarm_event_tx.sv
// Turns alarm flag edges into acknowledged UART event bytes for the control
// panel, with ack timeout, bounded retransmission and a sticky failure flag.
module alarm_event_tx
    import smart_home_pkg::*;
#(
    parameter int BAUD_DIV    = 434,
    parameter int ACK_TIMEOUT = 20000,
    parameter int MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             reset,
    alarm_event_tx_if.slave  bus
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t        state;
    logic [7:0]    prev, set_pend, clr_pend, rise, fall, set_clr, clr_clr;
    logic [7:0]    evt_byte, uart_data;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic          arb_assert, timeout, uart_start, bit_tick, done, tx_fail;
    logic [2:0]    arb_id, fail_id;
    logic [3:0]    bit_idx;

    assign rise = bus.alarm_in & ~prev;
    assign fall = ~bus.alarm_in & prev;

    // Any assert beats any clear; lowest id wins within the chosen class.
    always_comb begin
        arb_assert = |set_pend;
        arb_id     = '0;
        for (int i = 7; i >= 0; i--) begin
            if (arb_assert ? set_pend[i] : clr_pend[i]) arb_id = 3'(i);
        end
    end

    assign set_clr = (state == ST_LOAD &&  arb_assert) ? (8'b1 << arb_id) : 8'b0;
    assign clr_clr = (state == ST_LOAD && !arb_assert) ? (8'b1 << arb_id) : 8'b0;

    // A fresh edge in the same cycle as LOAD re-arms the bit rather than being lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev     <= '0;
            set_pend <= '0;
            clr_pend <= '0;
        end else begin
            prev     <= bus.alarm_in;
            set_pend <= (set_pend & ~set_clr) | rise;
            clr_pend <= (clr_pend & ~clr_clr) | fall;
        end
    end

    assign timeout    = (timer == TW'(ACK_TIMEOUT - 1));
    assign uart_start = (state == ST_LOAD) ||
                        (state == ST_WAIT_ACK && !bus.ack && timeout && retry != RW'(MAX_RETRY));
    assign uart_data  = (state == ST_LOAD) ? make_event(arb_assert, arb_id) : evt_byte;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            evt_byte <= '0;
            timer    <= '0;
            retry    <= '0;
            tx_fail  <= 1'b0;
            fail_id  <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (|set_pend || |clr_pend) state <= ST_LOAD;
                ST_LOAD: begin
                    evt_byte <= make_event(arb_assert, arb_id);
                    retry    <= '0;
                    state    <= ST_START;
                end
                ST_START: if (bit_tick) state <= ST_DATA;
                ST_DATA:  if (bit_tick && bit_idx == 4'd8) state <= ST_STOP;
                ST_STOP: begin
                    if (done) begin
                        timer <= '0;
                        state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // ack on the final timeout cycle still counts as delivered.
                    if (bus.ack) begin
                        state <= ST_IDLE;
                    end else if (timeout) begin
                        if (retry != RW'(MAX_RETRY)) begin
                            retry <= retry + 1'b1;
                            state <= ST_START;
                        end else begin
                            tx_fail <= 1'b1;
                            fail_id <= evt_byte[2:0];
                            state   <= ST_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.state   = state;
    assign bus.tx_fail = tx_fail;
    assign bus.fail_id = fail_id;

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk     (clk),
        .reset   (reset),
        .start   (uart_start),
        .data_in (uart_data),
        .tx      (bus.tx),
        .bit_tick(bit_tick),
        .bit_idx (bit_idx),
        .done    (done)
    );

endmodule

// File: tb/tb_alarm_event_tx.sv
// Bench for alarm_event_tx: a UART monitor decodes frames against a queue of
// expected event bytes; directed checks cover latency, ack, retry and reset.
module tb_alarm_event_tx;
    import smart_home_pkg::*;

    localparam int BAUD_DIV    = 4;
    localparam int ACK_TIMEOUT = 10;
    localparam int MAX_RETRY   = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    alarm_event_tx_if bus();

    alarm_event_tx #(
        .BAUD_DIV   (BAUD_DIV),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int n_checks    = 0;
    int n_errors    = 0;
    int frames_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // UART monitor: start bit seen at frame cycle 0, bits sampled mid-bit.
    initial begin
        logic [7:0] data;
        logic       ok;
        logic       stop_b;
        forever begin
            @(negedge clk);
            if (reset && bus.tx == 1'b0) begin
                ok     = 1'b1;
                data   = '0;
                stop_b = 1'b0;
                for (int c = 1; c < 10 * BAUD_DIV; c++) begin
                    @(negedge clk);
                    if (!reset) begin
                        ok = 1'b0;
                        break;
                    end
                    if (c >= 6 && c <= 34 && (c - 6) % 4 == 0) data[(c - 6) / 4] = bus.tx;
                    if (c == 38) stop_b = bus.tx;
                end
                if (ok) begin
                    frames_seen++;
                    check_val("stop_bit", 32'(stop_b), 32'd1);
                    check_val("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check_val("frame_byte", 32'(data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic wait_frames(input int target);
        int cnt = 0;
        while (frames_seen < target && cnt < 400) begin
            @(posedge clk);
            cnt++;
        end
        check_val("frame_arrived", 32'(frames_seen >= target), 32'd1);
    endtask

    task automatic ack_next(input int delay);
        int target = frames_seen + 1;
        wait_frames(target);
        repeat (delay + 1) @(negedge clk);
        check_val("busy_before_ack", 32'(bus.busy), 32'd1);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        check_val("busy_after_ack", 32'(bus.busy), 32'd0);
    endtask

    task automatic set_alarm(input logic [7:0] val);
        @(negedge clk);
        bus.alarm_in = val;
    endtask

    // Drive from idle and check tx stays high for cycles 1-2 and falls at cycle 3.
    task automatic set_alarm_latency(input logic [7:0] val);
        set_alarm(val);
        @(negedge clk);
        check_val("lat_c1_tx", 32'(bus.tx), 32'd1);
        check_val("lat_c1_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_val("lat_c2_tx", 32'(bus.tx), 32'd1);
        check_val("lat_c2_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check_val("lat_c3_tx", 32'(bus.tx), 32'd0);
    endtask

    task automatic check_gap();
        int n = 0;
        wait_frames(frames_seen + 1);
        while (n < 50) begin
            @(negedge clk);
            if (bus.tx == 1'b0) break;
            n++;
        end
        check_val("retry_gap", 32'(n), 32'(ACK_TIMEOUT));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alarm_in = '0;
        bus.ack      = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_tx", 32'(bus.tx), 32'd1);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_tx_fail", 32'(bus.tx_fail), 32'd0);
        check_val("rst_fail_id", 32'(bus.fail_id), 32'd0);
        check_val("rst_state", 32'(bus.state), 32'(ST_IDLE));
        reset = 1'b1;

        // Single fire assert, acked a few cycles after the stop bit.
        exp_q.push_back(make_event(1'b1, ALM_FIRE));
        set_alarm_latency(8'h01);
        ack_next(4);
        exp_q.push_back(make_event(1'b0, ALM_FIRE));
        set_alarm(8'h00);
        ack_next(0);

        // Simultaneous asserts go out lowest id first; clears likewise.
        exp_q.push_back(make_event(1'b1, ALM_FIRE));
        exp_q.push_back(make_event(1'b1, ALM_WIN0));
        set_alarm_latency(8'h05);
        ack_next(0);
        ack_next(0);
        exp_q.push_back(make_event(1'b0, ALM_FIRE));
        exp_q.push_back(make_event(1'b0, ALM_WIN0));
        set_alarm(8'h00);
        ack_next(0);
        ack_next(0);

        // Rain rises and falls while a fire frame is on the wire.
        exp_q.push_back(make_event(1'b1, ALM_FIRE));
        exp_q.push_back(make_event(1'b1, ALM_RAIN));
        exp_q.push_back(make_event(1'b0, ALM_RAIN));
        set_alarm(8'h01);
        repeat (12) @(negedge clk);
        set_alarm(8'h41);
        repeat (3) @(negedge clk);
        set_alarm(8'h01);
        ack_next(0);
        ack_next(0);
        ack_next(0);
        exp_q.push_back(make_event(1'b0, ALM_FIRE));
        set_alarm(8'h00);
        ack_next(0);

        // Door never acked: MAX_RETRY+1 frames, then the failure flag.
        repeat (MAX_RETRY + 1) exp_q.push_back(make_event(1'b1, ALM_DOOR));
        set_alarm_latency(8'h02);
        check_gap();
        check_gap();
        wait_frames(frames_seen + 1);
        repeat (ACK_TIMEOUT) @(negedge clk);
        check_val("fail_before", 32'(bus.tx_fail), 32'd0);
        check_val("busy_before_fail", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check_val("tx_fail_set", 32'(bus.tx_fail), 32'd1);
        check_val("fail_id_door", 32'(bus.fail_id), 32'(ALM_DOOR));
        check_val("busy_after_fail", 32'(bus.busy), 32'd0);
        exp_q.push_back(make_event(1'b0, ALM_DOOR));
        set_alarm(8'h00);
        ack_next(0);
        check_val("tx_fail_sticky", 32'(bus.tx_fail), 32'd1);

        // ack during DATA is ignored; ack on the last timeout cycle is accepted.
        exp_q.push_back(make_event(1'b1, ALM_WATER));
        exp_q.push_back(make_event(1'b1, ALM_WATER));
        set_alarm_latency(8'h80);
        repeat (10) @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        check_gap();
        wait_frames(frames_seen + 1);
        repeat (ACK_TIMEOUT) @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        check_val("late_ack_idle", 32'(bus.busy), 32'd0);
        check_val("late_ack_tx", 32'(bus.tx), 32'd1);
        check_val("late_ack_fail_id", 32'(bus.fail_id), 32'(ALM_DOOR));
        repeat (60) @(negedge clk);
        check_val("no_retry_busy", 32'(bus.busy), 32'd0);
        exp_q.push_back(make_event(1'b0, ALM_WATER));
        set_alarm(8'h00);
        ack_next(0);

        // Reset mid-DATA truncates the frame; fire still high is resent after.
        exp_q.push_back(make_event(1'b1, ALM_FIRE));
        set_alarm_latency(8'h01);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_val("midrst_tx", 32'(bus.tx), 32'd1);
        check_val("midrst_busy", 32'(bus.busy), 32'd0);
        check_val("midrst_tx_fail", 32'(bus.tx_fail), 32'd0);
        check_val("midrst_fail_id", 32'(bus.fail_id), 32'd0);
        repeat (2) @(negedge clk);
        exp_q.push_back(make_event(1'b1, ALM_FIRE));
        reset = 1'b1;
        @(negedge clk);
        check_val("rel_c1_tx", 32'(bus.tx), 32'd1);
        check_val("rel_c1_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_val("rel_c2_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check_val("rel_c3_tx", 32'(bus.tx), 32'd0);
        ack_next(0);

        repeat (20) @(negedge clk);
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
